// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the IF/DM memory bus arbiter.
// Holds the FSM state enum, owner encoding and parameter defaults.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Response timeout counter: clear, enable, terminal count.
// Ports: clk, rst, clr_i, en_i, tc_o (count equals TERM).
module arb_timeout_cnt #(
  parameter int W    = 8,
  parameter int TERM = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(TERM));

  // Holds at the terminal value so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (IF) and data (DM).
// Ports: if_* / dm_* requesters, mem_* port, arb_busy status.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int BW = DATA_W / 8;

  arb_state_e    state_q;
  owner_e        owner_q;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BW-1:0]     wstrb_q;

  logic idle, starved, if_win, dm_win;
  logic in_wait, to_tc, rsp_ok, rsp_to, rsp;
  logic [DATA_W-1:0] rsp_data;

  // Grants are combinational, so gate them off while in reset.
  assign idle    = (state_q == IDLE) && !rst;
  assign starved = (streak_q >= SW'(STARVE_MAX));
  assign if_win  = if_req && (!dm_req || starved);
  assign dm_win  = dm_req && !if_win;
  assign if_gnt  = idle && if_win;
  assign dm_gnt  = idle && dm_win;

  always_comb begin
    streak_d = streak_q;
    if (dm_gnt) begin
      streak_d = starved ? streak_q : streak_q + 1'b1;
    end else if (if_gnt) begin
      streak_d = '0;
    end
  end

  assign in_wait = (state_q == WAIT);

  arb_timeout_cnt #(
    .W    (CW),
    .TERM (TIMEOUT - 1)
  ) u_to (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_wait),
    .en_i  (in_wait),
    .tc_o  (to_tc)
  );

  // A real response beats a timeout landing on the same cycle.
  assign rsp_ok   = in_wait && mem_rvalid;
  assign rsp_to   = in_wait && !mem_rvalid && to_tc;
  assign rsp      = rsp_ok || rsp_to;
  assign rsp_data = rsp_ok ? mem_rdata : '0;

  assign if_rvalid = rsp && (owner_q == OWN_IF);
  assign dm_rvalid = rsp && (owner_q == OWN_DM);
  assign if_rdata  = if_rvalid ? rsp_data : '0;
  assign dm_rdata  = dm_rvalid ? rsp_data : '0;
  assign if_err    = if_rvalid && rsp_to;
  assign dm_err    = dm_rvalid && rsp_to;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign arb_busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      streak_q  <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      streak_q <= streak_d;
      unique case (state_q)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            state_q   <= ADDR;
            mem_req_q <= 1'b1;
            owner_q   <= dm_gnt ? OWN_DM : OWN_IF;
            mem_we_q  <= dm_gnt && dm_we;
            addr_q    <= dm_gnt ? dm_addr : if_addr;
            wdata_q   <= dm_gnt ? dm_wdata : '0;
            wstrb_q   <= dm_gnt ? dm_wstrb : '0;
          end
        end
        ADDR: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (rsp) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter.
// Directed transactions; a monitor checks gnt, mem and rsp queues.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        arb_busy;

  int errors = 0;
  int checks = 0;

  bit          gq[$];
  logic [68:0] mq[$];
  logic [33:0] rq[$];

  bit          e_g;
  logic [68:0] e_m;
  logic [33:0] e_r;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_wstrb   (dm_wstrb),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .dm_err     (dm_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .arb_busy   (arb_busy)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_txn(input bit dm, input bit we,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] st);
    gq.push_back(dm);
    mq.push_back({we, a, wd, st});
  endtask

  task automatic exp_rsp(input bit dm,
                         input logic [31:0] rd,
                         input bit err);
    rq.push_back({dm, rd, err});
  endtask

  task automatic wait_gnt(output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        ok = 1'b1;
        n = i;
        break;
      end
    end
    if (!ok) chk("gnt_bound", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input int gw, input int rw,
                           input logic [31:0] rd);
    mem_rvalid = 1'b0;
    mem_gnt = 1'b0;
    repeat (gw) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (rw) tick();
    mem_rvalid = 1'b1;
    mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || dm_gnt) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", {if_gnt, dm_gnt}, 0);
        end else begin
          e_g = gq.pop_front();
          chk("gnt_who", {if_gnt, dm_gnt},
              e_g ? 2'b01 : 2'b10);
        end
      end
      if (mem_req && mem_gnt) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected", 1, 0);
        end else begin
          e_m = mq.pop_front();
          chk("mem_payload",
              {mem_we, mem_addr, mem_wdata, mem_wstrb}, e_m);
        end
      end
      if (if_rvalid || dm_rvalid) begin
        chk("rsp_route",
            {if_rvalid && dm_rvalid,
             dm_rvalid ? if_rdata : dm_rdata,
             dm_rvalid ? if_err : dm_err}, 0);
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e_r = rq.pop_front();
          chk("rsp_data",
              {dm_rvalid,
               dm_rvalid ? dm_rdata : if_rdata,
               dm_rvalid ? dm_err : if_err}, e_r);
        end
      end
    end
  end

  logic [31:0] sdat [6];
  int n, hit;
  bit ok;

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_wstrb = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #2;
    chk("reset_ctrl",
        {if_gnt, dm_gnt, if_rvalid, dm_rvalid,
         if_err, dm_err, mem_req, mem_we, arb_busy}, 0);
    chk("reset_mem", {mem_addr, mem_wdata, mem_wstrb}, 0);
    tick();
    rst = 1'b0;
    tick();

    // fetch read
    exp_txn(0, 0, 32'h8000_0000, 0, 0);
    exp_rsp(0, 32'h0000_0093, 0);
    if_req = 1; if_addr = 32'h8000_0000;
    wait_gnt(n);
    if_req = 0;
    chk("t1_gnt_cycle", n, 0);
    chk("t1_mem", {mem_req, mem_we, mem_addr},
        {1'b1, 1'b0, 32'h8000_0000});
    mem_phase(0, 1, 32'h0000_0093);

    // simultaneous: DM write first, then IF
    exp_txn(1, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    exp_rsp(1, 0, 0);
    exp_txn(0, 0, 32'h8000_0004, 0, 0);
    exp_rsp(0, 32'h13, 0);
    if_req = 1; if_addr = 32'h8000_0004;
    dm_req = 1; dm_we = 1; dm_addr = 32'h1000;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    wait_gnt(n);
    dm_req = 0; dm_we = 0; dm_wdata = 0; dm_wstrb = 0;
    chk("t2_write", {mem_we, mem_wdata, mem_wstrb},
        {1'b1, 32'hDEAD_BEEF, 4'hF});
    mem_phase(0, 0, 0);
    wait_gnt(n);
    if_req = 0;
    chk("t2_if_next_idle", n, 0);
    mem_phase(0, 0, 32'h13);

    // starvation guard
    for (int i = 0; i < 6; i++) sdat[i] = 32'h100 + i;
    for (int i = 0; i < 4; i++) begin
      exp_txn(1, 0, 32'h5000, 0, 0);
      exp_rsp(1, sdat[i], 0);
    end
    exp_txn(0, 0, 32'h8000_0100, 0, 0);
    exp_rsp(0, sdat[4], 0);
    exp_txn(1, 0, 32'h5000, 0, 0);
    exp_rsp(1, sdat[5], 0);
    if_req = 1; if_addr = 32'h8000_0100;
    dm_req = 1; dm_addr = 32'h5000;
    for (int i = 0; i < 6; i++) begin
      wait_gnt(n);
      if (i == 4) if_req = 0;
      if (i == 5) dm_req = 0;
      mem_phase(0, 0, sdat[i]);
    end

    // backpressure, with a stray rvalid in ADDR
    exp_txn(1, 0, 32'h2000, 0, 0);
    exp_rsp(1, 32'hAA55, 0);
    exp_txn(0, 0, 32'h8000_0200, 0, 0);
    exp_rsp(0, 32'h17, 0);
    if_req = 1; if_addr = 32'h8000_0200;
    dm_req = 1; dm_addr = 32'h2000;
    wait_gnt(n);
    dm_req = 0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        mem_rvalid = 1; mem_rdata = 32'hBAD;
      end
      if (i == 6) begin
        mem_rvalid = 0; mem_rdata = 0;
      end
      @(negedge clk);
      if (!(mem_req && !mem_we && mem_addr == 32'h2000 &&
            arb_busy && !if_gnt && !dm_gnt &&
            !if_rvalid && !dm_rvalid))
        ok = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("bp_stable", ok, 1);
    mem_phase(0, 1, 32'hAA55);
    wait_gnt(n);
    if_req = 0;
    chk("bp_if_after", n, 0);
    mem_phase(0, 0, 32'h17);

    // timeout on a DM read
    exp_txn(1, 0, 32'h3000, 0, 0);
    exp_rsp(1, 0, 1);
    dm_req = 1; dm_addr = 32'h3000;
    wait_gnt(n);
    dm_req = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    hit = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dm_rvalid) begin
        hit = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("to_wait_cycle", hit, 8);
    chk("to_idle", arb_busy, 0);
    mem_rvalid = 1; mem_rdata = 32'h1234;
    #1;
    chk("to_stray", {if_rvalid, dm_rvalid}, 0);
    tick();
    mem_rvalid = 0; mem_rdata = 0;

    // reset mid-transaction
    exp_txn(1, 0, 32'h4000, 0, 0);
    dm_req = 1; dm_addr = 32'h4000;
    wait_gnt(n);
    dm_req = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    tick();
    chk("rst_pre_busy", arb_busy, 1);
    if_req = 1; if_addr = 32'h8000_0300;
    rst = 1;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_ctrl",
        {if_gnt, dm_gnt, if_rvalid, dm_rvalid,
         if_err, dm_err, mem_req, mem_we, arb_busy}, 0);
    chk("rst_data", {if_rdata, dm_rdata, mem_addr}, 0);
    if_req = 0;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_stray", {if_rvalid, dm_rvalid, arb_busy}, 0);
    tick();
    mem_rvalid = 0; mem_rdata = 0;

    // recovery fetch with memory wait states
    exp_txn(0, 0, 32'h8000_0300, 0, 0);
    exp_rsp(0, 32'h6F, 0);
    if_req = 1;
    wait_gnt(n);
    if_req = 0;
    chk("rec_gnt", n, 0);
    mem_phase(2, 0, 32'h6F);

    repeat (3) tick();
    chk("q_gnt_empty", gq.size(), 0);
    chk("q_mem_empty", mq.size(), 0);
    chk("q_rsp_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF, driven from the pc stage) and data load/store (DM, from the execute stage).
- Arbitrates requests and keeps one transaction outstanding on the memory side.
- Routes each response back to the requester that owns the transaction.
- Applies a per-transaction response timeout and a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. The write strobe is DATA_W/8 bits wide.
- STARVE_MAX, 4, maximum consecutive DM grants while if_req is pending; after that, IF is forced to win.
- TIMEOUT, 255, number of WAIT cycles without mem_rvalid before an error response is returned. Legal range is 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted; one-cycle pulse.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  DATA_W  fetch response data.
- if_err  out  1  fetch response is a timeout error.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_wstrb  in  DATA_W/8  byte enables.
- dm_gnt  out  1  data request accepted; one-cycle pulse.
- dm_rvalid  out  1  data response or write acknowledge valid.
- dm_rdata  out  DATA_W  read data.
- dm_err  out  1  data response is a timeout error.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response or write acknowledge.
- mem_rdata  in  DATA_W  memory read data.
- arb_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: clock is clk; rst is asynchronous and active-high.
  - On reset: state goes to IDLE, owner to IF, dm_streak to 0, timeout counter to 0.
  - Every output and every latched request register is forced to 0.
  - Reset mid-transaction discards that transaction; no response is delivered.
- States: IDLE, ADDR, WAIT.
- IDLE:
  - If any request is present, pick a winner. DM wins, unless if_req=1 and dm_streak>=STARVE_MAX, in which case IF wins.
  - The winner's gnt is driven combinationally high in this cycle.
  - On the clock edge: latch addr/we/wdata/wstrb into the mem_* registers (IF latches we=0 and wstrb=0), record owner, go to ADDR.
  - Requesters hold req and payload stable until gnt; a request dropped before gnt is legal and simply loses arbitration.
- ADDR:
  - mem_req=1 with the latched payload held stable.
  - On mem_gnt=1: drop mem_req on the next edge, clear the timeout counter, go to WAIT.
- WAIT:
  - mem_req=0. The timeout counter increments each cycle.
  - On mem_rvalid=1: owner's rvalid=1 and owner's rdata=mem_rdata, combinationally in the same cycle, with err=0. Go to IDLE.
  - If the counter reaches TIMEOUT-1 with no rvalid: owner's rvalid=1, err=1, rdata=0, go to IDLE.
- Response routing: the non-owner's rvalid, rdata and err are always 0. mem_rvalid in IDLE or ADDR is ignored (stray responses are dropped).
- Latency and throughput:
  - Request seen in IDLE at cycle t → mem_req at t+1.
  - With mem_gnt at t+1, the earliest response is at t+2.
  - Minimum back-to-back period is 3 cycles plus memory latency.
- Streak counter:
  - +1 on each DM grant, saturating at STARVE_MAX.
  - Reset to 0 on each IF grant.
  - Unchanged when no grant occurs.
- Write transactions also wait for mem_rvalid as their acknowledge. dm_rdata=mem_rdata is passed through; the core ignores it.

Decomposition:
- Shared package:
  - state enum {IDLE, ADDR, WAIT}.
  - owner encoding {OWN_IF=0, OWN_DM=1}.
  - default parameter constants.
- Sub-module arb_timeout_cnt: a clear/enable/terminal-count counter of width clog2(TIMEOUT+1).

Test Plan:
- Fetch read: if_req with addr 0x80000000; mem_gnt given immediately; mem_rvalid two cycles later with 0x00000093 → if_gnt at cycle 0; mem_req=1, mem_addr=0x80000000, mem_we=0 at cycle 1; if_rvalid=1 with if_rdata=0x00000093; dm outputs stay 0.
- Simultaneous requests: if_req and a dm write (0x1000, 0xDEADBEEF, strb 0xF) in the same IDLE cycle → dm_gnt first; mem_we=1 with those values; if_gnt in the next IDLE cycle; dm_streak=1, then 0.
- Starvation guard: STARVE_MAX=4, dm_req and if_req held continuously → grant order DM,DM,DM,DM,IF,DM...
- Memory backpressure: mem_gnt held low for 10 cycles → mem_req and payload stable for all 10 cycles; state remains ADDR; no gnt is issued to the other requester.
- Timeout: TIMEOUT=8, no mem_rvalid on a dm read → on the 8th WAIT cycle dm_rvalid=1, dm_err=1, dm_rdata=0; state returns to IDLE; a later stray mem_rvalid produces no rvalid.
- Reset mid-transaction: rst asserted in WAIT → all outputs 0 asynchronously, arb_busy=0; a mem_rvalid after reset is ignored.
